// File: rtl/lpc_pkg.sv
// Shared LPC definitions: FSM states, LAD nibble codes and response status codes.
// Used by the host initiator and the passive decoder.
package lpc_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_START,
      S_CYC,
      S_ADDR,
      S_WDATA,
      S_TAR1,
      S_SYNC,
      S_RDATA,
      S_TAR2,
      S_ABORT,
      S_ABORT_END,
      S_RESP
   } lpc_state_e;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_ERR     = 2'b01,
      ST_TIMEOUT = 2'b10
   } lpc_status_e;

   localparam logic [3:0] LPC_START  = 4'b0000;
   localparam logic [3:0] CYC_IO_RD  = 4'b0000;
   localparam logic [3:0] CYC_IO_WR  = 4'b0010;
   localparam logic [3:0] SYNC_READY = 4'b0000;
   localparam logic [3:0] SYNC_SHORT = 4'b0101;
   localparam logic [3:0] SYNC_LONG  = 4'b0110;
   localparam logic [3:0] SYNC_ERR   = 4'b1010;
   localparam logic [3:0] LAD_IDLE   = 4'b1111;

   localparam int ABORT_CLKS = 4;

   // Address goes out most-significant nibble first; idx 0 selects [15:12].
   function automatic logic [3:0] lpc_addr_nibble(input logic [15:0] addr, input logic [1:0] idx);
      logic [3:0] nib;
      case (idx)
         2'd0:    nib = addr[15:12];
         2'd1:    nib = addr[11:8];
         2'd2:    nib = addr[7:4];
         default: nib = addr[3:0];
      endcase
      return nib;
   endfunction

endpackage

// File: rtl/lpc_sync_watch.sv
// SYNC-phase watcher: classifies the peripheral SYNC nibble and runs the
// no-response and total-wait counters that decide a timeout.
module lpc_sync_watch
   import lpc_pkg::*;
#(
   parameter int NORESP_MAX = 3,
   parameter int WAIT_MAX   = 255
)
(
   input  logic       lpc_clock,
   input  logic       lpc_reset,
   input  logic       i_active,
   input  logic [3:0] i_lad,
   output logic       o_ready,
   output logic       o_error,
   output logic       o_timeout
);

   localparam logic [7:0] NORESP_LIM = 8'(NORESP_MAX);
   localparam logic [7:0] WAIT_LIM   = 8'(WAIT_MAX);

   logic [7:0] r_noresp_cnt;
   logic [7:0] r_total_cnt;
   logic [7:0] w_noresp_inc;
   logic [7:0] w_total_inc;
   logic [7:0] w_noresp_next;
   logic       w_is_ready;
   logic       w_is_err;
   logic       w_is_wait;

   assign w_is_err   = (i_lad == SYNC_ERR);
   assign w_is_ready = (i_lad == SYNC_READY) || w_is_err;
   assign w_is_wait  = (i_lad == SYNC_SHORT) || (i_lad == SYNC_LONG);

   assign w_noresp_inc  = (r_noresp_cnt == 8'hFF) ? 8'hFF : r_noresp_cnt + 8'd1;
   assign w_total_inc   = (r_total_cnt == 8'hFF) ? 8'hFF : r_total_cnt + 8'd1;
   assign w_noresp_next = w_is_wait ? 8'd0 : w_noresp_inc;

   // A valid SYNC on the last allowed clock still completes the cycle.
   assign o_ready   = i_active && w_is_ready;
   assign o_error   = i_active && w_is_err;
   assign o_timeout = i_active && !w_is_ready &&
                      ((w_noresp_next >= NORESP_LIM) || (w_total_inc >= WAIT_LIM));

   always_ff @(posedge lpc_clock or posedge lpc_reset) begin
      if (lpc_reset) begin
         r_noresp_cnt <= 8'd0;
         r_total_cnt  <= 8'd0;
      end else if (!i_active) begin
         r_noresp_cnt <= 8'd0;
         r_total_cnt  <= 8'd0;
      end else begin
         r_noresp_cnt <= w_noresp_next;
         r_total_cnt  <= w_total_inc;
      end
   end

endmodule

// File: rtl/lpc_host_io.sv
// LPC host initiator for I/O read/write cycles, one request at a time.
// Define LPC_HOST_ABORT_EN to drive an LFRAME# abort sequence on SYNC timeout.
module lpc_host_io
   import lpc_pkg::*;
#(
   parameter int NORESP_MAX = 3,
   parameter int WAIT_MAX   = 255
)
(
   input  logic        lpc_clock,
   input  logic        lpc_reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        resp_valid,
   output logic [7:0]  resp_rdata,
   output logic [1:0]  resp_status,
   output logic        lpc_frame_n,
   output logic [3:0]  lpc_ad_out,
   output logic        lpc_ad_oe,
   input  logic [3:0]  lpc_ad_in
);

   lpc_state_e  r_state;
   lpc_state_e  w_state_next;
   logic [1:0]  r_cnt;
   logic [1:0]  w_cnt_next;

   logic        r_write;
   logic [15:0] r_addr;
   logic [7:0]  r_wdata;
   logic [7:0]  r_rdata_acc;
   logic [7:0]  w_rdata_acc_next;
   lpc_status_e r_status_pend;
   lpc_status_e w_status_next;

   logic        r_frame_n;
   logic        w_frame_n_next;
   logic [3:0]  r_ad_out;
   logic [3:0]  w_ad_out_next;
   logic        r_ad_oe;
   logic        w_ad_oe_next;
   logic        r_resp_valid;
   logic [7:0]  r_resp_rdata;
   logic [1:0]  r_resp_status;

   logic        w_accept;
   logic        w_sync_active;
   logic        w_sync_ready;
   logic        w_sync_error;
   logic        w_sync_timeout;

   assign req_ready     = (r_state == S_IDLE);
   assign w_accept      = req_valid && req_ready;
   assign w_sync_active = (r_state == S_SYNC);

   assign resp_valid  = r_resp_valid;
   assign resp_rdata  = r_resp_rdata;
   assign resp_status = r_resp_status;
   assign lpc_frame_n = r_frame_n;
   assign lpc_ad_out  = r_ad_out;
   assign lpc_ad_oe   = r_ad_oe;

   lpc_sync_watch #(
      .NORESP_MAX (NORESP_MAX),
      .WAIT_MAX   (WAIT_MAX)
   ) u_sync_watch (
      .lpc_clock  (lpc_clock),
      .lpc_reset  (lpc_reset),
      .i_active   (w_sync_active),
      .i_lad      (lpc_ad_in),
      .o_ready    (w_sync_ready),
      .o_error    (w_sync_error),
      .o_timeout  (w_sync_timeout)
   );

   // Phase sequencer. r_cnt indexes clocks inside multi-clock phases.
   always_comb begin
      w_state_next     = r_state;
      w_cnt_next       = r_cnt;
      w_status_next    = r_status_pend;
      w_rdata_acc_next = r_rdata_acc;
      unique case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_state_next     = S_START;
               w_status_next    = ST_OK;
               w_rdata_acc_next = 8'h00;
            end
         end
         S_START: w_state_next = S_CYC;
         S_CYC: begin
            w_state_next = S_ADDR;
            w_cnt_next   = 2'd0;
         end
         S_ADDR: begin
            if (r_cnt == 2'd3) begin
               w_state_next = r_write ? S_WDATA : S_TAR1;
               w_cnt_next   = 2'd0;
            end else begin
               w_cnt_next = r_cnt + 2'd1;
            end
         end
         S_WDATA: begin
            if (r_cnt == 2'd1) begin
               w_state_next = S_TAR1;
               w_cnt_next   = 2'd0;
            end else begin
               w_cnt_next = r_cnt + 2'd1;
            end
         end
         S_TAR1: begin
            if (r_cnt == 2'd1) begin
               w_state_next = S_SYNC;
               w_cnt_next   = 2'd0;
            end else begin
               w_cnt_next = r_cnt + 2'd1;
            end
         end
         S_SYNC: begin
            if (w_sync_ready) begin
               w_state_next  = r_write ? S_TAR2 : S_RDATA;
               w_cnt_next    = 2'd0;
               w_status_next = w_sync_error ? ST_ERR : ST_OK;
            end else if (w_sync_timeout) begin
               w_cnt_next    = 2'd0;
               w_status_next = ST_TIMEOUT;
`ifdef LPC_HOST_ABORT_EN
               w_state_next  = S_ABORT;
`else
               w_state_next  = S_RESP;
`endif
            end
         end
         S_RDATA: begin
            if (r_cnt == 2'd0) begin
               w_rdata_acc_next[3:0] = lpc_ad_in;
            end else begin
               w_rdata_acc_next[7:4] = lpc_ad_in;
            end
            if (r_cnt == 2'd1) begin
               w_state_next = S_TAR2;
               w_cnt_next   = 2'd0;
            end else begin
               w_cnt_next = r_cnt + 2'd1;
            end
         end
         S_TAR2: begin
            if (r_cnt == 2'd1) begin
               w_state_next = S_RESP;
               w_cnt_next   = 2'd0;
            end else begin
               w_cnt_next = r_cnt + 2'd1;
            end
         end
         S_ABORT: begin
            if (r_cnt == 2'(ABORT_CLKS - 1)) begin
               w_state_next = S_ABORT_END;
               w_cnt_next   = 2'd0;
            end else begin
               w_cnt_next = r_cnt + 2'd1;
            end
         end
         S_ABORT_END: w_state_next = S_RESP;
         S_RESP:      w_state_next = S_IDLE;
         default:     w_state_next = S_IDLE;
      endcase
   end

   // Pin values are decoded from the upcoming state so they register in step with it.
   always_comb begin
      w_frame_n_next = 1'b1;
      w_ad_out_next  = LAD_IDLE;
      w_ad_oe_next   = 1'b0;
      unique case (w_state_next)
         S_START: begin
            w_frame_n_next = 1'b0;
            w_ad_out_next  = LPC_START;
            w_ad_oe_next   = 1'b1;
         end
         S_CYC: begin
            w_ad_out_next = r_write ? CYC_IO_WR : CYC_IO_RD;
            w_ad_oe_next  = 1'b1;
         end
         S_ADDR: begin
            w_ad_out_next = lpc_addr_nibble(r_addr, w_cnt_next);
            w_ad_oe_next  = 1'b1;
         end
         S_WDATA: begin
            w_ad_out_next = w_cnt_next[0] ? r_wdata[7:4] : r_wdata[3:0];
            w_ad_oe_next  = 1'b1;
         end
         S_TAR1: begin
            w_ad_oe_next = (w_cnt_next == 2'd0);
         end
         S_ABORT: begin
            w_frame_n_next = 1'b0;
            w_ad_oe_next   = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge lpc_clock or posedge lpc_reset) begin
      if (lpc_reset) begin
         r_state       <= S_IDLE;
         r_cnt         <= 2'd0;
         r_write       <= 1'b0;
         r_addr        <= 16'h0000;
         r_wdata       <= 8'h00;
         r_rdata_acc   <= 8'h00;
         r_status_pend <= ST_OK;
         r_frame_n     <= 1'b1;
         r_ad_out      <= LAD_IDLE;
         r_ad_oe       <= 1'b0;
         r_resp_valid  <= 1'b0;
         r_resp_rdata  <= 8'h00;
         r_resp_status <= ST_OK;
      end else begin
         r_state       <= w_state_next;
         r_cnt         <= w_cnt_next;
         r_rdata_acc   <= w_rdata_acc_next;
         r_status_pend <= w_status_next;
         r_frame_n     <= w_frame_n_next;
         r_ad_out      <= w_ad_out_next;
         r_ad_oe       <= w_ad_oe_next;
         r_resp_valid  <= (w_state_next == S_RESP);
         if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
         end
         // Response fields only change on a completion and hold otherwise.
         if (w_state_next == S_RESP) begin
            r_resp_rdata  <= r_write ? 8'h00 : w_rdata_acc_next;
            r_resp_status <= w_status_next;
         end
      end
   end

endmodule

// File: tb/tb_lpc_host_io.sv
// Self-checking bench for lpc_host_io: directed and random I/O cycles against a
// per-clock pin/response model built from the LPC cycle rules.
module tb_lpc_host_io;

   localparam int NORESP = 3;
   localparam int WAITMX = 10;

   logic        lpc_clock = 1'b0;
   logic        lpc_reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        resp_valid;
   logic [7:0]  resp_rdata;
   logic [1:0]  resp_status;
   logic        lpc_frame_n;
   logic [3:0]  lpc_ad_out;
   logic        lpc_ad_oe;
   logic [3:0]  lpc_ad_in;

   lpc_host_io #(.NORESP_MAX(NORESP), .WAIT_MAX(WAITMX)) dut (
      .lpc_clock   (lpc_clock),
      .lpc_reset   (lpc_reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .resp_status (resp_status),
      .lpc_frame_n (lpc_frame_n),
      .lpc_ad_out  (lpc_ad_out),
      .lpc_ad_oe   (lpc_ad_oe),
      .lpc_ad_in   (lpc_ad_in)
   );

   always #5 lpc_clock = ~lpc_clock;

   int n_cmp  = 0;
   int n_fail = 0;

   // Expected per-clock {frame_n, oe, lad-if-driven} starting at the START clock.
   logic [5:0] exp_tr [64];
   logic [3:0] in_tr  [64];
   int         exp_L;
   logic [7:0] exp_rdata;
   logic [1:0] exp_status;

   logic [5:0] obs_tr [64];
   logic       obs_rv [64];
   logic [7:0] obs_rdata;
   logic [1:0] obs_status;
   int         obs_lat;
   int         obs_resp_idx;
   logic       obs_ready_after;

   task automatic build_model(input logic w, input logic [15:0] a, input logic [7:0] wd,
                              input logic [63:0] sc, input logic [7:0] rd);
      int n;
      int k;
      int noresp;
      bit done;
      bit tout;
      logic [3:0] code;
      for (int i = 0; i < 64; i++) begin
         exp_tr[i] = 6'b10_1111;
         in_tr[i]  = 4'hF;
      end
      n = 0;
      exp_tr[n] = {2'b01, 4'h0}; n++;
      exp_tr[n] = {2'b11, (w ? 4'h2 : 4'h0)}; n++;
      for (int j = 3; j >= 0; j--) begin
         exp_tr[n] = {2'b11, a[4*j +: 4]}; n++;
      end
      if (w) begin
         exp_tr[n] = {2'b11, wd[3:0]}; n++;
         exp_tr[n] = {2'b11, wd[7:4]}; n++;
      end
      exp_tr[n] = {2'b11, 4'hF}; n++;
      exp_tr[n] = {2'b10, 4'hF}; n++;
      noresp = 0;
      k = 0;
      done = 0;
      tout = 0;
      exp_status = 2'b00;
      while (!done && !tout) begin
         code = (k < 16) ? sc[4*k +: 4] : 4'hF;
         in_tr[n] = code; n++; k++;
         if (code == 4'h0 || code == 4'hA) begin
            done = 1;
            exp_status = (code == 4'hA) ? 2'b01 : 2'b00;
         end else begin
            noresp = (code == 4'h5 || code == 4'h6) ? 0 : noresp + 1;
            if (noresp >= NORESP || k >= WAITMX) tout = 1;
         end
      end
      exp_rdata = 8'h00;
      if (done) begin
         if (!w) begin
            in_tr[n] = rd[3:0]; n++;
            in_tr[n] = rd[7:4]; n++;
            exp_rdata = rd;
         end
         n += 2;
      end else begin
         exp_status = 2'b10;
`ifdef LPC_HOST_ABORT_EN
         for (int j = 0; j < 4; j++) begin
            exp_tr[n] = {2'b01, 4'hF}; n++;
         end
         n++;
`endif
      end
      exp_L = n;
   endtask

   task automatic run_txn(input logic w, input logic [15:0] a, input logic [7:0] wd,
                          input logic [63:0] sc, input logic [7:0] rd, input bit b2b,
                          input logic nw, input logic [15:0] na, input logic [7:0] nwd);
      build_model(w, a, wd, sc, rd);
      req_write = w;
      req_addr  = a;
      req_wdata = wd;
      req_valid = 1'b1;
      lpc_ad_in = 4'hF;
      obs_lat = -1;
      obs_resp_idx = -1;
      obs_rdata = 8'hxx;
      obs_status = 2'bxx;
      obs_ready_after = 1'bx;
      for (int t = 1; t <= 8 && obs_lat < 0; t++) begin
         @(negedge lpc_clock);
         if (lpc_frame_n === 1'b0) obs_lat = t;
      end
      req_valid = 1'b0;
      if (obs_lat < 0) return;
      for (int i = 0; i <= exp_L + 1; i++) begin
         if (i > 0) @(negedge lpc_clock);
         obs_tr[i] = {lpc_frame_n, lpc_ad_oe, (lpc_ad_oe ? lpc_ad_out : 4'hF)};
         obs_rv[i] = resp_valid;
         if (resp_valid === 1'b1 && obs_resp_idx < 0) begin
            obs_resp_idx = i;
            obs_rdata    = resp_rdata;
            obs_status   = resp_status;
         end
         lpc_ad_in = in_tr[i];
         if (i == exp_L && b2b) begin
            req_write = nw;
            req_addr  = na;
            req_wdata = nwd;
            req_valid = 1'b1;
         end
      end
      obs_ready_after = req_ready;
   endtask

   task automatic test_reset();
      lpc_reset = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 16'h0;
      req_wdata = 8'h0;
      lpc_ad_in = 4'hF;
      #1;
      n_cmp++;
      if ({lpc_frame_n, lpc_ad_oe, lpc_ad_out} !== 6'b10_1111) begin
         n_fail++;
         $display("FAIL reset_pins: got %b required 101111", {lpc_frame_n, lpc_ad_oe, lpc_ad_out});
      end
      n_cmp++;
      if ({resp_valid, resp_rdata, resp_status} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_resp: got v=%b d=%h s=%b required 0/00/00", resp_valid, resp_rdata, resp_status);
      end
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: got %b required 1", req_ready);
      end
      repeat (2) @(negedge lpc_clock);
      lpc_reset = 1'b0;
      @(negedge lpc_clock);
      $display("reset: ready=%b frame_n=%b oe=%b", req_ready, lpc_frame_n, lpc_ad_oe);
   endtask

   task automatic test_directed();
      logic        d_w    [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [15:0] d_a    [5] = '{16'h0080, 16'h03F8, 16'h1234, 16'h0060, 16'hBEEF};
      logic [7:0]  d_wd   [5] = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
      logic [63:0] d_sc   [5] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_0555,
                                  64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFF,
                                  64'h6666_6666_6666_6666};
      logic [7:0]  d_rd   [5] = '{8'h00, 8'hC4, 8'h21, 8'h77, 8'h99};
      logic [7:0]  d_rexp [5] = '{8'h00, 8'hC4, 8'h21, 8'h00, 8'h00};
      logic [1:0]  d_st   [5] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10};
`ifdef LPC_HOST_ABORT_EN
      int          d_idx  [5] = '{13, 16, 13, 16, 23};
`else
      int          d_idx  [5] = '{13, 16, 13, 11, 18};
`endif
      for (int c = 0; c < 5; c++) begin
         run_txn(d_w[c], d_a[c], d_wd[c], d_sc[c], d_rd[c], 1'b0, 1'b0, 16'h0, 8'h0);
         n_cmp++;
         if (obs_lat !== 1) begin
            n_fail++;
            $display("FAIL dir%0d_start: latency %0d required 1", c, obs_lat);
         end else begin
            for (int i = 0; i <= exp_L + 1; i++) begin
               n_cmp++;
               if (obs_tr[i] !== exp_tr[i] || obs_rv[i] !== (i == exp_L)) begin
                  n_fail++;
                  $display("FAIL dir%0d_clk%0d: got pins=%b rv=%b required pins=%b rv=%b",
                           c, i, obs_tr[i], obs_rv[i], exp_tr[i], (i == exp_L));
               end
            end
            n_cmp++;
            if (obs_resp_idx !== d_idx[c] || obs_rdata !== d_rexp[c] || obs_status !== d_st[c]) begin
               n_fail++;
               $display("FAIL dir%0d_resp: got idx=%0d d=%h s=%b required idx=%0d d=%h s=%b",
                        c, obs_resp_idx, obs_rdata, obs_status, d_idx[c], d_rexp[c], d_st[c]);
            end
            n_cmp++;
            if (obs_ready_after !== 1'b1) begin
               n_fail++;
               $display("FAIL dir%0d_ready: got %b required 1", c, obs_ready_after);
            end
         end
         $display("directed %0d: w=%b addr=%h resp@%0d d=%h s=%b", c, d_w[c], d_a[c],
                  obs_resp_idx, obs_rdata, obs_status);
      end
   endtask

   task automatic test_random();
      logic        w;
      logic [15:0] a;
      logic [7:0]  wd;
      logic [7:0]  rd;
      logic [63:0] sc;
      logic [3:0]  nib;
      for (int t = 0; t < 24; t++) begin
         w  = 1'($urandom);
         a  = 16'($urandom);
         wd = 8'($urandom);
         rd = 8'($urandom);
         for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 9))
               0:       nib = 4'h0;
               1:       nib = 4'hA;
               2, 3:    nib = 4'h5;
               4, 5:    nib = 4'h6;
               6, 7:    nib = 4'hF;
               default: nib = 4'($urandom);
            endcase
            sc[4*k +: 4] = nib;
         end
         run_txn(w, a, wd, sc, rd, 1'b0, 1'b0, 16'h0, 8'h0);
         n_cmp++;
         if (obs_lat !== 1) begin
            n_fail++;
            $display("FAIL rnd%0d_start: latency %0d required 1", t, obs_lat);
         end else begin
            for (int i = 0; i <= exp_L + 1; i++) begin
               n_cmp++;
               if (obs_tr[i] !== exp_tr[i] || obs_rv[i] !== (i == exp_L)) begin
                  n_fail++;
                  $display("FAIL rnd%0d_clk%0d: got pins=%b rv=%b required pins=%b rv=%b",
                           t, i, obs_tr[i], obs_rv[i], exp_tr[i], (i == exp_L));
               end
            end
            n_cmp++;
            if (obs_rdata !== exp_rdata || obs_status !== exp_status) begin
               n_fail++;
               $display("FAIL rnd%0d_resp: got d=%h s=%b required d=%h s=%b",
                        t, obs_rdata, obs_status, exp_rdata, exp_status);
            end
         end
         $display("random %0d: w=%b addr=%h sync=%h d=%h s=%b", t, w, a, sc, obs_rdata, obs_status);
      end
   endtask

   task automatic test_back_to_back();
      logic        w  [4];
      logic [15:0] a  [4];
      logic [7:0]  wd [4];
      logic [7:0]  rd;
      for (int t = 0; t < 4; t++) begin
         w[t]  = 1'($urandom);
         a[t]  = 16'($urandom);
         wd[t] = 8'($urandom);
      end
      for (int t = 0; t < 4; t++) begin
         rd = 8'($urandom);
         if (t < 3)
            run_txn(w[t], a[t], wd[t], 64'hFFFF_FFFF_FFFF_0560, rd, 1'b1, w[t+1], a[t+1], wd[t+1]);
         else
            run_txn(w[t], a[t], wd[t], 64'hFFFF_FFFF_FFFF_0560, rd, 1'b0, 1'b0, 16'h0, 8'h0);
         n_cmp++;
         if (obs_lat !== 1) begin
            n_fail++;
            $display("FAIL b2b%0d_start: latency %0d required 1", t, obs_lat);
         end else begin
            n_cmp++;
            if (obs_tr[exp_L + 1] !== exp_tr[exp_L + 1] || obs_ready_after !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b%0d_gap: got pins=%b ready=%b required pins=%b ready=1",
                        t, obs_tr[exp_L + 1], obs_ready_after, exp_tr[exp_L + 1]);
            end
            n_cmp++;
            if (obs_resp_idx !== exp_L || obs_rdata !== exp_rdata || obs_status !== exp_status) begin
               n_fail++;
               $display("FAIL b2b%0d_resp: got idx=%0d d=%h s=%b required idx=%0d d=%h s=%b",
                        t, obs_resp_idx, obs_rdata, obs_status, exp_L, exp_rdata, exp_status);
            end
         end
         $display("back_to_back %0d: w=%b addr=%h d=%h s=%b", t, w[t], a[t], obs_rdata, obs_status);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      bit rv_seen;
      req_write = 1'b0;
      req_addr  = 16'h2E5C;
      req_valid = 1'b1;
      lpc_ad_in = 4'hF;
      seen = 0;
      for (int t = 0; t < 8 && !seen; t++) begin
         @(negedge lpc_clock);
         if (lpc_frame_n === 1'b0) seen = 1;
      end
      req_valid = 1'b0;
      n_cmp++;
      if (!seen) begin
         n_fail++;
         $display("FAIL midrst_start: no START within 8 clocks");
      end
      repeat (3) @(negedge lpc_clock);
      n_cmp++;
      if (lpc_ad_oe !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_addr: got oe=%b required 1 before reset", lpc_ad_oe);
      end
      #2 lpc_reset = 1'b1;
      #1;
      n_cmp++;
      if (lpc_ad_oe !== 1'b0 || lpc_frame_n !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_release: got oe=%b frame_n=%b required 0/1", lpc_ad_oe, lpc_frame_n);
      end
      rv_seen = 0;
      repeat (2) begin
         @(negedge lpc_clock);
         if (resp_valid !== 1'b0) rv_seen = 1;
      end
      lpc_reset = 1'b0;
      @(negedge lpc_clock);
      n_cmp++;
      if (req_ready !== 1'b1 || lpc_frame_n !== 1'b1 || lpc_ad_oe !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_after: got ready=%b frame_n=%b oe=%b required 1/1/0",
                  req_ready, lpc_frame_n, lpc_ad_oe);
      end
      repeat (20) begin
         @(negedge lpc_clock);
         if (resp_valid !== 1'b0) rv_seen = 1;
      end
      n_cmp++;
      if (rv_seen) begin
         n_fail++;
         $display("FAIL midrst_noresp: got resp_valid=1 required 0");
      end
      $display("reset_mid: ready=%b oe=%b frame_n=%b", req_ready, lpc_ad_oe, lpc_frame_n);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_directed();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
